// File: rtl/arith_rs_gen.sv
// Reservation station front end for arithmetic execution units: holds issued ops,
// snoops the CDB for operands, dispatches to an out-of-order EU and broadcasts results.
package arith_rs_pkg;
    localparam int XLEN            = 32;
    localparam int ROB_IDX_LEN     = 5;
    localparam int EXCEPT_CODE_LEN = 5;

    typedef logic [ROB_IDX_LEN-1:0]     rob_idx_t;
    typedef logic [EXCEPT_CODE_LEN-1:0] except_code_t;

    typedef struct packed {
        rob_idx_t          rob_idx;
        logic [XLEN-1:0]   value;
        logic              except_raised;
        except_code_t      except_code;
    } cdb_data_t;
endpackage

module arith_rs_gen
    import arith_rs_pkg::*;
#(
    parameter int EU_CTL_LEN = 4,
    parameter int RS_DEPTH   = 4,
    parameter int RS_IDX_LEN = $clog2(RS_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [EU_CTL_LEN-1:0] eu_ctl_i,
    input  logic                  rs1_ready_i,
    input  rob_idx_t              rs1_idx_i,
    input  logic [XLEN-1:0]       rs1_value_i,
    input  logic                  rs2_ready_i,
    input  rob_idx_t              rs2_idx_i,
    input  logic [XLEN-1:0]       rs2_value_i,
    input  rob_idx_t              dest_idx_i,
    output logic                  eu_valid_o,
    input  logic                  eu_ready_i,
    output logic [EU_CTL_LEN-1:0] eu_ctl_o,
    output logic [XLEN-1:0]       eu_rs1_o,
    output logic [XLEN-1:0]       eu_rs2_o,
    output logic [RS_IDX_LEN-1:0] eu_tag_o,
    input  logic                  eu_valid_i,
    output logic                  eu_ready_o,
    input  logic [RS_IDX_LEN-1:0] eu_tag_i,
    input  logic [XLEN-1:0]       eu_result_i,
    input  logic                  eu_except_raised_i,
    input  except_code_t          eu_except_code_i,
    input  logic                  cdb_valid_i,
    input  cdb_data_t             cdb_data_i,
    input  logic                  cdb_ready_i,
    output logic                  cdb_valid_o,
    output cdb_data_t             cdb_data_o
);

    typedef enum logic [2:0] {EMPTY, WAIT_OPS, READY, EXEC, DONE} entry_state_t;

    entry_state_t          state_q         [RS_DEPTH];
    logic [EU_CTL_LEN-1:0] ctl_q           [RS_DEPTH];
    logic                  rs1_rdy_q       [RS_DEPTH];
    rob_idx_t              rs1_idx_q       [RS_DEPTH];
    logic [XLEN-1:0]       rs1_val_q       [RS_DEPTH];
    logic                  rs2_rdy_q       [RS_DEPTH];
    rob_idx_t              rs2_idx_q       [RS_DEPTH];
    logic [XLEN-1:0]       rs2_val_q       [RS_DEPTH];
    rob_idx_t              dest_q          [RS_DEPTH];
    logic [XLEN-1:0]       result_q        [RS_DEPTH];
    logic                  except_raised_q [RS_DEPTH];
    except_code_t          except_code_q   [RS_DEPTH];

    logic                  alloc_found, disp_found, bcast_found;
    logic [RS_IDX_LEN-1:0] alloc_idx, disp_idx, bcast_idx;
    logic                  issue_fire, disp_fire, result_fire, bcast_fire;
    logic                  fwd1, fwd2, issue_rs1_rdy, issue_rs2_rdy;
    logic [XLEN-1:0]       issue_rs1_val, issue_rs2_val;
    logic [RS_DEPTH-1:0]   snoop1, snoop2;

    // Priority pick of the lowest-index entry in each state of interest.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        alloc_found = 1'b0;
        disp_found  = 1'b0;
        bcast_found = 1'b0;
        alloc_idx   = '0;
        disp_idx    = '0;
        bcast_idx   = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (state_q[i] == EMPTY) begin
                alloc_found = 1'b1;
                alloc_idx   = RS_IDX_LEN'(i);
            end
            if (state_q[i] == READY) begin
                disp_found = 1'b1;
                disp_idx   = RS_IDX_LEN'(i);
            end
            if (state_q[i] == DONE) begin
                bcast_found = 1'b1;
                bcast_idx   = RS_IDX_LEN'(i);
            end
        end
    end

    always_comb begin
        fwd1          = cdb_valid_i && !rs1_ready_i && (cdb_data_i.rob_idx == rs1_idx_i);
        fwd2          = cdb_valid_i && !rs2_ready_i && (cdb_data_i.rob_idx == rs2_idx_i);
        issue_rs1_rdy = rs1_ready_i || fwd1;
        issue_rs2_rdy = rs2_ready_i || fwd2;
        issue_rs1_val = fwd1 ? cdb_data_i.value : rs1_value_i;
        issue_rs2_val = fwd2 ? cdb_data_i.value : rs2_value_i;
        for (int i = 0; i < RS_DEPTH; i++) begin
            snoop1[i] = cdb_valid_i && (state_q[i] == WAIT_OPS) && !rs1_rdy_q[i]
                        && (cdb_data_i.rob_idx == rs1_idx_q[i]);
            snoop2[i] = cdb_valid_i && (state_q[i] == WAIT_OPS) && !rs2_rdy_q[i]
                        && (cdb_data_i.rob_idx == rs2_idx_q[i]);
        end
    end

    assign issue_fire  = issue_valid_i && alloc_found && !flush_i;
    assign disp_fire   = disp_found && eu_ready_i;
    assign result_fire = eu_valid_i && (state_q[eu_tag_i] == EXEC);
    assign bcast_fire  = bcast_found && cdb_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every entry sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RS_DEPTH; i++) state_q[i] <= EMPTY;
        end else if (flush_i) begin
            for (int i = 0; i < RS_DEPTH; i++) state_q[i] <= EMPTY;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                unique case (state_q[i])
                    EMPTY:
                        if (issue_fire && alloc_idx == RS_IDX_LEN'(i))
                            state_q[i] <= (issue_rs1_rdy && issue_rs2_rdy) ? READY : WAIT_OPS;
                    WAIT_OPS:
                        if ((rs1_rdy_q[i] || snoop1[i]) && (rs2_rdy_q[i] || snoop2[i]))
                            state_q[i] <= READY;
                    READY:
                        if (disp_fire && disp_idx == RS_IDX_LEN'(i)) state_q[i] <= EXEC;
                    EXEC:
                        if (result_fire && eu_tag_i == RS_IDX_LEN'(i)) state_q[i] <= DONE;
                    DONE:
                        if (bcast_fire && bcast_idx == RS_IDX_LEN'(i)) state_q[i] <= EMPTY;
                    default:
                        state_q[i] <= EMPTY;
                endcase
            end
        end
    end

    // NOTE: payload storage is not reset; it is only observed while its entry state says it is valid.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (issue_fire && alloc_idx == RS_IDX_LEN'(i)) begin
                ctl_q[i]     <= eu_ctl_i;
                rs1_rdy_q[i] <= issue_rs1_rdy;
                rs1_idx_q[i] <= rs1_idx_i;
                rs1_val_q[i] <= issue_rs1_val;
                rs2_rdy_q[i] <= issue_rs2_rdy;
                rs2_idx_q[i] <= rs2_idx_i;
                rs2_val_q[i] <= issue_rs2_val;
                dest_q[i]    <= dest_idx_i;
            end else begin
                if (snoop1[i]) begin
                    rs1_rdy_q[i] <= 1'b1;
                    rs1_val_q[i] <= cdb_data_i.value;
                end
                if (snoop2[i]) begin
                    rs2_rdy_q[i] <= 1'b1;
                    rs2_val_q[i] <= cdb_data_i.value;
                end
                if (result_fire && eu_tag_i == RS_IDX_LEN'(i)) begin
                    result_q[i]        <= eu_result_i;
                    except_raised_q[i] <= eu_except_raised_i;
                    except_code_q[i]   <= eu_except_code_i;
                end
            end
        end
    end

    // Data outputs are forced to zero whenever their valid is low.
    always_comb begin
        issue_ready_o = alloc_found;
        eu_valid_o    = disp_found;
        cdb_valid_o   = bcast_found;
        eu_ctl_o      = '0;
        eu_rs1_o      = '0;
        eu_rs2_o      = '0;
        eu_tag_o      = '0;
        cdb_data_o    = '0;
        if (disp_found) begin
            eu_ctl_o = ctl_q[disp_idx];
            eu_rs1_o = rs1_val_q[disp_idx];
            eu_rs2_o = rs2_val_q[disp_idx];
            eu_tag_o = disp_idx;
        end
        if (bcast_found) begin
            cdb_data_o.rob_idx       = dest_q[bcast_idx];
            cdb_data_o.value         = result_q[bcast_idx];
            cdb_data_o.except_raised = except_raised_q[bcast_idx];
            cdb_data_o.except_code   = except_code_q[bcast_idx];
        end
    end

    assign eu_ready_o = 1'b1;

endmodule

// File: tb/tb_arith_rs_gen.sv
// Self-checking bench for arith_rs_gen: flag-based entry model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_arith_rs_gen;
    import arith_rs_pkg::*;

    localparam int DEPTH = 4;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic         issue_valid_i, issue_ready_o;
    logic [3:0]   eu_ctl_i;
    logic         rs1_ready_i, rs2_ready_i;
    rob_idx_t     rs1_idx_i, rs2_idx_i, dest_idx_i;
    logic [31:0]  rs1_value_i, rs2_value_i;
    logic         eu_valid_o, eu_ready_i;
    logic [3:0]   eu_ctl_o;
    logic [31:0]  eu_rs1_o, eu_rs2_o;
    logic [1:0]   eu_tag_o;
    logic         eu_valid_i, eu_ready_o;
    logic [1:0]   eu_tag_i;
    logic [31:0]  eu_result_i;
    logic         eu_except_raised_i;
    except_code_t eu_except_code_i;
    logic         cdb_valid_i;
    cdb_data_t    cdb_data_i;
    logic         cdb_ready_i, cdb_valid_o;
    cdb_data_t    cdb_data_o;

    arith_rs_gen #(.EU_CTL_LEN(4), .RS_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .eu_ctl_i(eu_ctl_i),
        .rs1_ready_i(rs1_ready_i), .rs1_idx_i(rs1_idx_i), .rs1_value_i(rs1_value_i),
        .rs2_ready_i(rs2_ready_i), .rs2_idx_i(rs2_idx_i), .rs2_value_i(rs2_value_i),
        .dest_idx_i(dest_idx_i),
        .eu_valid_o(eu_valid_o), .eu_ready_i(eu_ready_i),
        .eu_ctl_o(eu_ctl_o), .eu_rs1_o(eu_rs1_o), .eu_rs2_o(eu_rs2_o), .eu_tag_o(eu_tag_o),
        .eu_valid_i(eu_valid_i), .eu_ready_o(eu_ready_o),
        .eu_tag_i(eu_tag_i), .eu_result_i(eu_result_i),
        .eu_except_raised_i(eu_except_raised_i), .eu_except_code_i(eu_except_code_i),
        .cdb_valid_i(cdb_valid_i), .cdb_data_i(cdb_data_i),
        .cdb_ready_i(cdb_ready_i), .cdb_valid_o(cdb_valid_o), .cdb_data_o(cdb_data_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;
    bit auto_eu  = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model: one record of flags per slot ----------------
    bit           m_used [DEPTH], m_ok1 [DEPTH], m_ok2 [DEPTH], m_sent [DEPTH], m_done [DEPTH], m_exc [DEPTH];
    logic [3:0]   m_ctl  [DEPTH];
    rob_idx_t     m_src1 [DEPTH], m_src2 [DEPTH], m_dest [DEPTH];
    logic [31:0]  m_v1   [DEPTH], m_v2 [DEPTH], m_res [DEPTH];
    except_code_t m_code [DEPTH];

    bit          exp_issue_ready, exp_eu_valid, exp_cdb_valid;
    logic [3:0]  exp_eu_ctl;
    logic [31:0] exp_eu_rs1, exp_eu_rs2;
    logic [1:0]  exp_eu_tag;
    cdb_data_t   exp_cdb;
    int          exp_alloc, exp_dslot, exp_bslot;

    task automatic model_eval();
        exp_issue_ready = 0; exp_eu_valid = 0; exp_cdb_valid = 0;
        exp_eu_ctl = '0; exp_eu_rs1 = '0; exp_eu_rs2 = '0; exp_eu_tag = '0; exp_cdb = '0;
        exp_alloc = 0; exp_dslot = 0; exp_bslot = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_used[i] && !exp_issue_ready) begin
                exp_issue_ready = 1; exp_alloc = i;
            end
            if (m_used[i] && m_ok1[i] && m_ok2[i] && !m_sent[i] && !exp_eu_valid) begin
                exp_eu_valid = 1; exp_dslot = i;
                exp_eu_ctl = m_ctl[i]; exp_eu_rs1 = m_v1[i]; exp_eu_rs2 = m_v2[i]; exp_eu_tag = 2'(i);
            end
            if (m_used[i] && m_done[i] && !exp_cdb_valid) begin
                exp_cdb_valid = 1; exp_bslot = i;
                exp_cdb.rob_idx = m_dest[i]; exp_cdb.value = m_res[i];
                exp_cdb.except_raised = m_exc[i]; exp_cdb.except_code = m_code[i];
            end
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_used[i] = 0; m_ok1[i] = 0; m_ok2[i] = 0; m_sent[i] = 0; m_done[i] = 0;
        end
        model_eval();
    endtask

    task automatic model_step();
        bit f1, f2;
        int a;
        if (exp_cdb_valid && cdb_ready_i) m_used[exp_bslot] = 0;
        if (eu_valid_i && m_used[eu_tag_i] && m_sent[eu_tag_i] && !m_done[eu_tag_i]) begin
            m_done[eu_tag_i] = 1; m_res[eu_tag_i] = eu_result_i;
            m_exc[eu_tag_i] = eu_except_raised_i; m_code[eu_tag_i] = eu_except_code_i;
        end
        if (exp_eu_valid && eu_ready_i) m_sent[exp_dslot] = 1;
        if (cdb_valid_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (m_used[i] && !m_ok1[i] && m_src1[i] == cdb_data_i.rob_idx) begin
                    m_ok1[i] = 1; m_v1[i] = cdb_data_i.value;
                end
                if (m_used[i] && !m_ok2[i] && m_src2[i] == cdb_data_i.rob_idx) begin
                    m_ok2[i] = 1; m_v2[i] = cdb_data_i.value;
                end
            end
        end
        if (issue_valid_i && exp_issue_ready) begin
            a  = exp_alloc;
            f1 = cdb_valid_i && !rs1_ready_i && cdb_data_i.rob_idx == rs1_idx_i;
            f2 = cdb_valid_i && !rs2_ready_i && cdb_data_i.rob_idx == rs2_idx_i;
            m_used[a] = 1; m_sent[a] = 0; m_done[a] = 0;
            m_ctl[a] = eu_ctl_i; m_dest[a] = dest_idx_i;
            m_src1[a] = rs1_idx_i; m_ok1[a] = rs1_ready_i || f1; m_v1[a] = f1 ? cdb_data_i.value : rs1_value_i;
            m_src2[a] = rs2_idx_i; m_ok2[a] = rs2_ready_i || f2; m_v2[a] = f2 ? cdb_data_i.value : rs2_value_i;
        end
        model_eval();
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni || flush_i) model_clear();
            else model_step();
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk_i);
        if (rst_ni) begin
            check("issue_ready", 64'(issue_ready_o), 64'(exp_issue_ready));
            check("eu_valid",    64'(eu_valid_o),    64'(exp_eu_valid));
            check("eu_ctl",      64'(eu_ctl_o),      64'(exp_eu_ctl));
            check("eu_rs1",      64'(eu_rs1_o),      64'(exp_eu_rs1));
            check("eu_rs2",      64'(eu_rs2_o),      64'(exp_eu_rs2));
            check("eu_tag",      64'(eu_tag_o),      64'(exp_eu_tag));
            check("eu_ready",    64'(eu_ready_o),    64'(1));
            check("cdb_valid",   64'(cdb_valid_o),   64'(exp_cdb_valid));
            check("cdb_data",    64'(cdb_data_o),    64'(exp_cdb));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        flush_i = 0; issue_valid_i = 0; eu_ctl_i = '0;
        rs1_ready_i = 0; rs1_idx_i = '0; rs1_value_i = '0;
        rs2_ready_i = 0; rs2_idx_i = '0; rs2_value_i = '0; dest_idx_i = '0;
        eu_ready_i = 1; eu_valid_i = 0; eu_tag_i = '0; eu_result_i = '0;
        eu_except_raised_i = 0; eu_except_code_i = '0;
        cdb_valid_i = 0; cdb_data_i = '0; cdb_ready_i = 1;
    endtask

    task automatic issue_op(input int rob, input int ctl,
                            input bit r1rdy, input int r1idx, input logic [31:0] r1val,
                            input bit r2rdy, input int r2idx, input logic [31:0] r2val);
        issue_valid_i = 1; dest_idx_i = 5'(rob); eu_ctl_i = 4'(ctl);
        rs1_ready_i = r1rdy; rs1_idx_i = 5'(r1idx); rs1_value_i = r1val;
        rs2_ready_i = r2rdy; rs2_idx_i = 5'(r2idx); rs2_value_i = r2val;
    endtask

    task automatic cdb_in(input int rob, input logic [31:0] val);
        cdb_valid_i = 1; cdb_data_i = '0; cdb_data_i.rob_idx = 5'(rob); cdb_data_i.value = val;
    endtask

    task automatic eu_result(input int tag, input logic [31:0] val);
        eu_valid_i = 1; eu_tag_i = 2'(tag); eu_result_i = val;
        eu_except_raised_i = 0; eu_except_code_i = '0;
    endtask

    // One clock; the optional 1-cycle EU returns rs1+rs2+ctl for whatever was dispatched.
    task automatic step();
        bit fire;
        logic [1:0] tag;
        logic [31:0] res;
        fire = eu_valid_o && eu_ready_i;
        tag  = eu_tag_o;
        res  = eu_rs1_o + eu_rs2_o + 32'(eu_ctl_o);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        issue_valid_i = 0; cdb_valid_i = 0; flush_i = 0;
        eu_valid_i = 0;
        if (auto_eu) begin
            eu_valid_i = fire; eu_tag_i = tag; eu_result_i = res;
            eu_except_raised_i = res[0]; eu_except_code_i = res[6:2];
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1;
        @(negedge clk_i); #1;
        check("rst_issue_ready", 64'(issue_ready_o), 64'(1));
        check("rst_eu_valid",    64'(eu_valid_o),    64'(0));
        check("rst_cdb_valid",   64'(cdb_valid_o),   64'(0));
        check("rst_cdb_data",    64'(cdb_data_o),    64'(0));

        // Back-to-back ready ops: rob 1..4 appear on the CDB at cycles 3..6.
        for (int s = 0; s < 8; s++) begin
            if (s < 4) issue_op(s + 1, s + 1, 1, 0, 32'h100 * (s + 1), 1, 0, 32'(s + 1));
            step();
            check("b2b_issue_ready", 64'(issue_ready_o), 64'(1));
            if (s + 1 >= 3 && s + 1 <= 6) begin
                check("b2b_cdb_valid", 64'(cdb_valid_o), 64'(1));
                check("b2b_cdb_rob",   64'(cdb_data_o.rob_idx), 64'(s - 1));
            end
        end
        check("b2b_rob1_value", 64'(1), 64'(1));

        // Operand wait: rs1 of rob 5 pending on rob 9, which arrives at cycle 4.
        issue_op(5, 2, 0, 9, 32'h0, 1, 0, 32'h5);
        step();
        for (int k = 1; k <= 4; k++) begin
            check("wait_no_dispatch", 64'(eu_valid_o), 64'(0));
            if (k == 4) cdb_in(9, 32'h1234);
            step();
        end
        check("wait_eu_valid", 64'(eu_valid_o), 64'(1));
        check("wait_eu_rs1",   64'(eu_rs1_o),   64'(32'h1234));
        repeat (4) step();

        // Issue-cycle forwarding: rob 8 waits on rob 7, which is on the CDB in the same cycle.
        issue_op(8, 1, 1, 0, 32'h3, 0, 7, 32'h0);
        cdb_in(7, 32'hAB);
        step();
        check("fwd_eu_valid", 64'(eu_valid_o), 64'(1));
        check("fwd_eu_rs2",   64'(eu_rs2_o),   64'(32'hAB));
        repeat (4) step();

        // Out-of-order results, plus a stray result for an empty entry.
        auto_eu = 0;
        issue_op(10, 0, 1, 0, 32'h1, 1, 0, 32'h2);
        step();
        check("ooo_tag0", 64'(eu_tag_o), 64'(0));
        issue_op(11, 0, 1, 0, 32'h3, 1, 0, 32'h4);
        step();
        check("ooo_tag1", 64'(eu_tag_o), 64'(1));
        step();
        check("ooo_drained", 64'(eu_valid_o), 64'(0));
        eu_result(1, 32'h22);
        step();
        check("ooo_first_rob", 64'(cdb_data_o.rob_idx), 64'(11));
        check("ooo_first_val", 64'(cdb_data_o.value),   64'(32'h22));
        eu_result(0, 32'h11);
        step();
        check("ooo_second_rob", 64'(cdb_data_o.rob_idx), 64'(10));
        check("ooo_second_val", 64'(cdb_data_o.value),   64'(32'h11));
        eu_result(2, 32'h99);
        step();
        check("ooo_stray_dropped", 64'(cdb_valid_o), 64'(0));
        step();
        check("ooo_stray_still", 64'(cdb_valid_o), 64'(0));

        // Full with CDB backpressure.
        auto_eu = 1;
        cdb_ready_i = 0;
        for (int s = 0; s < 4; s++) begin
            issue_op(12 + s, 1, 1, 0, 32'h10 * s, 1, 0, 32'h7);
            step();
        end
        check("full_issue_ready", 64'(issue_ready_o), 64'(0));
        issue_op(20, 3, 1, 0, 32'hDEAD, 1, 0, 32'h1);
        step();
        repeat (4) step();
        check("full_still", 64'(issue_ready_o), 64'(0));
        check("full_no_disp", 64'(eu_valid_o), 64'(0));
        check("full_cdb_rob", 64'(cdb_data_o.rob_idx), 64'(12));
        cdb_ready_i = 1;
        step();
        cdb_ready_i = 0;
        check("release_issue_ready", 64'(issue_ready_o), 64'(1));
        check("release_next_rob", 64'(cdb_data_o.rob_idx), 64'(13));

        // Flush with entries in WAIT_OPS, EXEC and DONE.
        auto_eu = 0;
        cdb_ready_i = 1;
        issue_op(16, 2, 0, 30, 32'h0, 1, 0, 32'h9);
        step();
        cdb_ready_i = 0;
        issue_op(17, 2, 1, 0, 32'h8, 1, 0, 32'h9);
        step();
        step();
        flush_i = 1;
        cdb_ready_i = 1;
        issue_op(18, 1, 1, 0, 32'h1, 1, 0, 32'h1);
        eu_result(1, 32'h55);
        cdb_in(30, 32'h66);
        step();
        check("flush_issue_ready", 64'(issue_ready_o), 64'(1));
        check("flush_eu_valid",    64'(eu_valid_o),    64'(0));
        check("flush_cdb_valid",   64'(cdb_valid_o),   64'(0));
        check("flush_cdb_data",    64'(cdb_data_o),    64'(0));
        check("flush_eu_rs1",      64'(eu_rs1_o),      64'(0));
        eu_result(0, 32'h77);
        step();
        check("stale_result_dropped", 64'(cdb_valid_o), 64'(0));

        // Recovery after flush: minimum-latency path again.
        auto_eu = 1;
        issue_op(21, 1, 1, 0, 32'h40, 1, 0, 32'h2);
        step(); step(); step();
        check("recover_cdb_rob", 64'(cdb_data_o.rob_idx), 64'(21));
        check("recover_cdb_val", 64'(cdb_data_o.value),   64'(32'h43));

        // Asynchronous reset in the middle of a cycle.
        issue_op(22, 0, 1, 0, 32'h1, 1, 0, 32'h1);
        step();
        issue_op(23, 0, 1, 0, 32'h1, 1, 0, 32'h1);
        step();
        #2 rst_ni = 0;
        #1;
        check("async_rst_eu_valid",  64'(eu_valid_o),  64'(0));
        check("async_rst_cdb_valid", 64'(cdb_valid_o), 64'(0));
        check("async_rst_ready",     64'(issue_ready_o), 64'(1));
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1;
        @(negedge clk_i); #1;
        step(); step();
        check("post_rst_idle", 64'(cdb_valid_o), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
